// File: rtl/ascon_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// ascon_stream_ctrl_if : command, plaintext/ciphertext stream and core bundle
// Revision: 1.0
// ============================================================================
interface ascon_stream_ctrl_if;
    logic         start_i;
    logic [4:0]   nb_blocks_i;
    logic [63:0]  da_i;
    logic [63:0]  pt_data_i;
    logic         pt_valid_i;
    logic         pt_ready_o;
    logic [63:0]  ct_data_o;
    logic         ct_valid_o;
    logic         ct_ready_i;
    logic [127:0] tag_o;
    logic         done_o;
    logic         busy_o;
    logic         init_o;
    logic         associate_data_o;
    logic         finalisation_o;
    logic         data_valid_o;
    logic [63:0]  data_o;
    logic         end_initialisation_i;
    logic         end_associate_i;
    logic         cipher_valid_i;
    logic         end_cipher_i;
    logic         end_tag_i;
    logic [63:0]  cipher_i;
    logic [127:0] core_tag_i;

    modport slave (
        input  start_i, nb_blocks_i, da_i, pt_data_i, pt_valid_i, ct_ready_i,
        input  end_initialisation_i, end_associate_i, cipher_valid_i,
        input  end_cipher_i, end_tag_i, cipher_i, core_tag_i,
        output pt_ready_o, ct_data_o, ct_valid_o, tag_o, done_o, busy_o,
        output init_o, associate_data_o, finalisation_o, data_valid_o, data_o
    );

    modport master (
        output start_i, nb_blocks_i, da_i, pt_data_i, pt_valid_i, ct_ready_i,
        output end_initialisation_i, end_associate_i, cipher_valid_i,
        output end_cipher_i, end_tag_i, cipher_i, core_tag_i,
        input  pt_ready_o, ct_data_o, ct_valid_o, tag_o, done_o, busy_o,
        input  init_o, associate_data_o, finalisation_o, data_valid_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/ascon_stream_ctrl.sv
`default_nettype none
// ============================================================================
// ascon_stream_ctrl : sequences one AEAD message (init, AD, PT blocks, final)
// Revision: 1.0
// ============================================================================
module ascon_stream_ctrl #(
    parameter int MAX_BLOCKS = 23
) (
    input  wire logic          clock_i,
    input  wire logic          reset_i,
    ascon_stream_ctrl_if.slave bus
);
    localparam int KW = $clog2(MAX_BLOCKS + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INIT       = 4'd1,
        S_AD         = 4'd2,
        S_PT_WAIT    = 4'd3,
        S_PT_ISSUE   = 4'd4,
        S_CT_HOLD    = 4'd5,
        S_FINAL_WAIT = 4'd6,
        S_FINAL      = 4'd7,
        S_FINAL_HOLD = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  n_q, n_d;
    logic [63:0]    da_q, da_d;
    logic [63:0]    buf_q, buf_d;
    logic [63:0]    ct_q, ct_d;
    logic [127:0]   tag_q, tag_d;

    logic [KW-1:0]  n_start;
    logic [KW-1:0]  n_last;
    logic           pt_ready;
    logic           ct_valid;
    logic           done;
    logic           init;
    logic           assoc;
    logic           fin;
    logic           dvalid;
    logic [63:0]    data;
    logic           unused_end_cipher;

    // end_cipher_i carries no sequencing information for this controller
    assign unused_end_cipher = bus.end_cipher_i;

    always_comb begin
        if (bus.nb_blocks_i == 5'd0) begin
            n_start = KW'(1);
        end else if (32'(bus.nb_blocks_i) > 32'(MAX_BLOCKS)) begin
            n_start = KW'(MAX_BLOCKS);
        end else begin
            n_start = KW'(bus.nb_blocks_i);
        end
    end

    assign n_last = n_q - KW'(1);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        da_d     = da_q;
        buf_d    = buf_q;
        ct_d     = ct_q;
        tag_d    = tag_q;
        pt_ready = 1'b0;
        ct_valid = 1'b0;
        done     = 1'b0;
        init     = 1'b0;
        assoc    = 1'b0;
        fin      = 1'b0;
        dvalid   = 1'b0;
        data     = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    n_d     = n_start;
                    da_d    = bus.da_i;
                    k_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                init = 1'b1;
                if (bus.end_initialisation_i) state_d = S_AD;
            end
            S_AD: begin
                assoc  = 1'b1;
                dvalid = 1'b1;
                data   = da_q;
                if (bus.end_associate_i) state_d = S_PT_WAIT;
            end
            S_PT_WAIT, S_FINAL_WAIT: begin
                pt_ready = 1'b1;
                if (bus.pt_valid_i) begin
                    buf_d   = bus.pt_data_i;
                    state_d = (k_q < n_last) ? S_PT_ISSUE : S_FINAL;
                end
            end
            S_PT_ISSUE: begin
                dvalid = 1'b1;
                data   = buf_q;
                if (bus.cipher_valid_i) begin
                    ct_d    = bus.cipher_i;
                    k_d     = k_q + KW'(1);
                    state_d = S_CT_HOLD;
                end
            end
            S_CT_HOLD: begin
                ct_valid = 1'b1;
                // the last block of a multi-block message waits in FINAL_WAIT
                if (bus.ct_ready_i) state_d = (k_q == n_last) ? S_FINAL_WAIT : S_PT_WAIT;
            end
            S_FINAL: begin
                fin    = 1'b1;
                dvalid = 1'b1;
                data   = buf_q;
                if (bus.end_tag_i) begin
                    ct_d    = bus.cipher_i;
                    tag_d   = bus.core_tag_i;
                    state_d = S_FINAL_HOLD;
                end
            end
            S_FINAL_HOLD: begin
                ct_valid = 1'b1;
                if (bus.ct_ready_i) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            da_q    <= 64'd0;
            buf_q   <= 64'd0;
            ct_q    <= 64'd0;
            tag_q   <= 128'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            da_q    <= da_d;
            buf_q   <= buf_d;
            ct_q    <= ct_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.pt_ready_o       = pt_ready;
    assign bus.ct_valid_o       = ct_valid;
    assign bus.ct_data_o        = ct_q;
    assign bus.tag_o            = tag_q;
    assign bus.done_o           = done;
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.init_o           = init;
    assign bus.associate_data_o = assoc;
    assign bus.finalisation_o   = fin;
    assign bus.data_valid_o     = dvalid;
    assign bus.data_o           = data;
endmodule
`default_nettype wire

// File: tb/tb_ascon_stream_ctrl.sv
`default_nettype none
// Randomized bench for ascon_stream_ctrl: a small core model answers the control
// outputs, a reference computes expected ciphertext/tag into queues for a monitor.
module tb_ascon_stream_ctrl;
    logic clk;
    logic rst;

    ascon_stream_ctrl_if bus();

    ascon_stream_ctrl #(.MAX_BLOCKS(23)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int lat = 0;
    int rdy_mode = 0;
    int icnt = 0;

    logic [63:0]  exp_ct[$];
    logic [127:0] exp_tag[$];
    int           exp_n[$];

    function automatic logic [63:0] cfun(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'hA5C3_0F1E_5A3C_F0E1;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", nm, what);
    endtask

    // core model: answers each active control after lat idle cycles, else injects noise
    initial begin
        int cdly;
        logic [63:0] acc;
        logic [63:0] cda;
        cdly = 0; acc = 0; cda = 0;
        bus.end_initialisation_i = 0; bus.end_associate_i = 0; bus.cipher_valid_i = 0;
        bus.end_cipher_i = 0; bus.end_tag_i = 0; bus.cipher_i = 0; bus.core_tag_i = 0;
        forever begin
            @(posedge clk); #1;
            bus.end_initialisation_i = 0;
            bus.end_associate_i      = 0;
            bus.cipher_valid_i       = 0;
            bus.end_tag_i            = 0;
            bus.end_cipher_i         = 1'($urandom_range(0, 1));
            bus.cipher_i             = {$urandom, $urandom};
            bus.core_tag_i           = {$urandom, $urandom, $urandom, $urandom};
            if (!(bus.init_o || bus.associate_data_o || bus.finalisation_o || bus.data_valid_o)) begin
                cdly = 0;
                bus.cipher_valid_i = 1'($urandom_range(0, 1));
                bus.end_tag_i      = 1'($urandom_range(0, 1));
            end else if (cdly < lat) begin
                cdly++;
            end else begin
                cdly = 0;
                if (bus.init_o) begin
                    bus.end_initialisation_i = 1; acc = 0; icnt = 0;
                end else if (bus.associate_data_o) begin
                    bus.end_associate_i = 1; cda = bus.data_o;
                end else if (bus.finalisation_o) begin
                    bus.end_tag_i  = 1;
                    bus.cipher_i   = cfun(bus.data_o);
                    bus.core_tag_i = {cda, acc + bus.data_o};
                end else begin
                    bus.cipher_valid_i = 1;
                    bus.cipher_i       = cfun(bus.data_o);
                    acc  = acc + bus.data_o;
                    icnt++;
                end
            end
        end
    end

    // ciphertext sink: 0 = always ready, 1 = random, 2 = stall each beat 5 cycles
    initial begin
        int st;
        st = 0;
        bus.ct_ready_i = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.ct_ready_i = 1;
                1: bus.ct_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.ct_valid_o && st < 5) begin
                        bus.ct_ready_i = 0; st++;
                    end else begin
                        bus.ct_ready_i = 1;
                        if (bus.ct_valid_o) st = 0;
                    end
                end
            endcase
        end
    end

    // monitor
    initial begin
        logic        prev_hold;
        logic        prev_done;
        logic [63:0] prev_ct;
        int          last_beat;
        prev_hold = 0; prev_done = 0; prev_ct = 0; last_beat = -10;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold = 0; prev_done = 0;
            end else begin
                if (prev_done) check("done_one_cycle", 128'({bus.done_o, bus.busy_o}), 128'd0);
                if (prev_hold && bus.ct_valid_o) check("ct_stable", 128'(bus.ct_data_o), 128'(prev_ct));
                if (bus.ct_valid_o && !bus.ct_ready_i)
                    check("stall_quiet", 128'({bus.pt_ready_o, bus.data_valid_o}), 128'd0);
                if (bus.ct_valid_o && bus.ct_ready_i) begin
                    if (exp_ct.size() == 0) fail_now("ct_unexpected", $sformatf("got beat %h expected none", bus.ct_data_o));
                    else check("ct_data", 128'(bus.ct_data_o), 128'(exp_ct.pop_front()));
                    last_beat = cyc;
                end
                if (bus.done_o) begin
                    if (exp_tag.size() == 0) begin
                        fail_now("done_unexpected", "got done_o=1 expected 0");
                    end else begin
                        check("tag", bus.tag_o, exp_tag.pop_front());
                        check("done_after_beat", 128'(cyc - last_beat), 128'd1);
                        check("issue_visits", 128'(icnt), 128'(exp_n.pop_front() - 1));
                        check("beats_left", 128'(exp_ct.size()), 128'd0);
                        done_seen++;
                    end
                end
                prev_hold = bus.ct_valid_o && !bus.ct_ready_i;
                prev_ct   = bus.ct_data_o;
                prev_done = bus.done_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, 128'({bus.pt_ready_o, bus.ct_valid_o, bus.done_o, bus.busy_o, bus.init_o,
                                  bus.associate_data_o, bus.finalisation_o, bus.data_valid_o}), 128'd0);
        check({nm, "_data"}, 128'({bus.ct_data_o, bus.data_o}), 128'd0);
        check({nm, "_tag"}, bus.tag_o, 128'd0);
    endtask

    task automatic send_pt(input logic [63:0] d);
        int t;
        t = 0;
        bus.pt_valid_i = 1; bus.pt_data_i = d;
        while (!bus.pt_ready_o && t < 3000) begin tick(); t++; end
        if (t >= 3000) fail_now("pt_timeout", "got no pt_ready_o expected a transfer");
        tick();
        bus.pt_valid_i = 0; bus.pt_data_i = {$urandom, $urandom};
    endtask

    task automatic run_msg(input logic [4:0] nb, input int l, input int mode, input bit poke);
        int n, d0, t;
        logic [63:0] da, sum;
        logic [63:0] pt[$];
        n = (nb == 0) ? 1 : ((int'(nb) > 23) ? 23 : int'(nb));
        lat = l; rdy_mode = mode;
        da = {$urandom, $urandom}; sum = 0;
        for (int i = 0; i < n; i++) begin
            pt.push_back({$urandom, $urandom});
            sum = sum + pt[i];
            exp_ct.push_back(cfun(pt[i]));
        end
        exp_tag.push_back({da, sum});
        exp_n.push_back(n);
        d0 = done_seen;
        bus.start_i = 1; bus.nb_blocks_i = nb; bus.da_i = da;
        tick();
        bus.start_i = 0; bus.nb_blocks_i = 5'($urandom); bus.da_i = {$urandom, $urandom};
        if (poke) begin
            tick();
            bus.start_i = 1;
            tick();
            bus.start_i = 0;
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_pt(pt[i]);
        end
        t = 0;
        while (done_seen == d0 && t < 5000) begin tick(); t++; end
        if (t >= 5000) fail_now("done_timeout", "got no done_o expected one");
    endtask

    initial begin
        int t;
        rst = 1;
        bus.start_i = 0; bus.nb_blocks_i = 0; bus.da_i = 0;
        bus.pt_valid_i = 0; bus.pt_data_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_all_zero("reset");
        repeat (3) tick();
        check_all_zero("idle_after_reset");

        run_msg(5'd3, 4, 0, 0);
        run_msg(5'd1, 4, 0, 0);
        run_msg(5'd0, 2, 1, 0);
        run_msg(5'd31, 1, 1, 0);
        run_msg(5'd3, 0, 2, 0);
        run_msg(5'd4, 3, 1, 1);

        // reset while a block is being issued to the core
        lat = 4; rdy_mode = 0;
        bus.start_i = 1; bus.nb_blocks_i = 5'd4; bus.da_i = {$urandom, $urandom};
        tick();
        bus.start_i = 0;
        send_pt({$urandom, $urandom});
        t = 0;
        while (!(bus.data_valid_o && !bus.associate_data_o && !bus.finalisation_o) && t < 100) begin
            tick(); t++;
        end
        if (t >= 100) fail_now("issue_timeout", "got no PT_ISSUE expected one");
        rst = 1;
        tick();
        rst = 0;
        check_all_zero("mid_reset");
        repeat (10) tick();
        check_all_zero("after_mid_reset");

        for (int m = 0; m < 14; m++)
            run_msg(5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
